// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared encodings and defaults for cache_mem_arbiter
//
// Contents:
//   arb_state_t   : IDLE / BUSY / GAP arbiter states
//   arb_op_t      : OP_RD (line fill) / OP_WR (write-through)
//   DEF_BURST_LEN : default read beats per line fill
//   DEF_TIMEOUT   : default watchdog limit in idle BUSY cycles
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_TIMEOUT   = 64;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker
//
// Ports:
//   req  [1:0] in  : request vector, bit X = cache X requesting
//   last       in  : index of the most recent owner
//   pick [1:0] out : one-hot winner, 00 when nobody requests
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      // On a tie the requester that did not own the bus last time wins.
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing one memory port between two caches
//
// Optional feature: define ARB_WATCHDOG_EN to abort a BUSY transaction after
// TIMEOUT cycles without a beat and raise the sticky timeout_err flag.
//
// Ports:
//   clock, reset_n              : rising-edge clock, asynchronous active-low reset
//   addr_cX/rd_cX/wr_cX/wdata_cX : cache X request side (requests held until done)
//   rdata_cX/ready_cX            : cache X response side (ready_cX active-low beat)
//   addr_mem/rd_mem/wr_mem/wdata_mem : registered memory command
//   rdata_mem/ready_mem          : memory response (ready_mem active-low beat)
//   grant                        : one-hot current owner, 00 when idle or in the gap
//   timeout_err                  : sticky watchdog abort flag
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_c0,
  input  logic              rd_c0,
  input  logic              wr_c0,
  input  logic [DATA_W-1:0] wdata_c0,
  output logic [DATA_W-1:0] rdata_c0,
  output logic              ready_c0,
  input  logic [ADDR_W-1:0] addr_c1,
  input  logic              rd_c1,
  input  logic              wr_c1,
  input  logic [DATA_W-1:0] wdata_c1,
  output logic [DATA_W-1:0] rdata_c1,
  output logic              ready_c1,
  output logic [ADDR_W-1:0] addr_mem,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [DATA_W-1:0] wdata_mem,
  input  logic [DATA_W-1:0] rdata_mem,
  input  logic              ready_mem,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam logic [2:0] LP_BURST = 3'(BURST_LEN);

  arb_state_t        r_state;
  arb_op_t           r_op;
  logic              r_owner;
  logic              r_last;
  logic [2:0]        r_beats;
  logic [ADDR_W-1:0] r_addr_mem;
  logic [DATA_W-1:0] r_wdata_mem;
  logic              r_rd_mem;
  logic              r_wr_mem;
  logic [1:0]        r_grant;

  logic [1:0]        w_req;
  logic              w_last_eff;
  logic [1:0]        w_pick;
  logic              w_sel;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_beat;
  logic [2:0]        w_beats_nxt;
  logic              w_done;
  logic              w_abort;

  assign w_req = {rd_c1 | wr_c1, rd_c0 | wr_c0};

  // GAP already arbitrates for the next transaction so a new grant lands one
  // cycle after the last beat; the owner just finished counts as last there.
  assign w_last_eff = (r_state == GAP) ? r_owner : r_last;

  rr_pick2 u_pick (
    .req  (w_req),
    .last (w_last_eff),
    .pick (w_pick)
  );

  assign w_sel       = w_pick[1];
  assign w_sel_wr    = w_sel ? wr_c1 : wr_c0;   // write wins over a simultaneous read
  assign w_sel_addr  = w_sel ? addr_c1 : addr_c0;
  assign w_sel_wdata = w_sel ? wdata_c1 : wdata_c0;

  assign w_beat      = (r_state == BUSY) && !ready_mem;
  assign w_beats_nxt = (r_beats == LP_BURST) ? r_beats : r_beats + 3'd1;
  assign w_done      = w_beat && ((r_op == OP_WR) ? (w_beats_nxt == 3'd1)
                                                  : (w_beats_nxt == LP_BURST));

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_timeout_err;

  assign w_abort = (r_state == BUSY) && ready_mem && (r_wdog == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state != BUSY) || !ready_mem) begin
        r_wdog <= '0;
      end else if (!w_abort) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_abort     = 1'b0;
  // Always 0 in this build.
  assign timeout_err = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_op        <= OP_RD;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_beats     <= 3'd0;
      r_addr_mem  <= '0;
      r_wdata_mem <= '0;
      r_rd_mem    <= 1'b0;
      r_wr_mem    <= 1'b0;
      r_grant     <= 2'b00;
    end else begin
      case (r_state)
        IDLE, GAP: begin
          if (r_state == GAP) begin
            r_last <= r_owner;
          end
          if (|w_pick) begin
            r_state     <= BUSY;
            r_owner     <= w_sel;
            r_op        <= w_sel_wr ? OP_WR : OP_RD;
            r_addr_mem  <= w_sel_addr;
            r_wdata_mem <= w_sel_wdata;
            r_grant     <= w_pick;
            r_beats     <= 3'd0;
            r_rd_mem    <= !w_sel_wr;
            r_wr_mem    <= w_sel_wr;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (w_beat) begin
            r_beats <= w_beats_nxt;
          end
          // Requests are not looked at here: a started transfer always runs out.
          if (w_done || w_abort) begin
            r_state  <= GAP;
            r_rd_mem <= 1'b0;
            r_wr_mem <= 1'b0;
            r_grant  <= 2'b00;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign addr_mem  = r_addr_mem;
  assign wdata_mem = r_wdata_mem;
  assign rd_mem    = r_rd_mem;
  assign wr_mem    = r_wr_mem;
  assign grant     = r_grant;

  assign ready_c0  = ((r_state == BUSY) && (r_owner == 1'b0)) ? ready_mem : 1'b1;
  assign ready_c1  = ((r_state == BUSY) && (r_owner == 1'b1)) ? ready_mem : 1'b1;
  assign rdata_c0  = rdata_mem;
  assign rdata_c1  = rdata_mem;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  localparam int BL = 4;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr_c0, addr_c1, addr_mem;
  logic        rd_c0, wr_c0, rd_c1, wr_c1;
  logic [7:0]  wdata_c0, wdata_c1, rdata_c0, rdata_c1;
  logic        ready_c0, ready_c1;
  logic        rd_mem, wr_mem;
  logic [7:0]  wdata_mem, rdata_mem;
  logic        ready_mem;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;
  int m_last   = 1;

  bit          pend [2];
  bit          opw  [2];
  logic [15:0] ad   [2];
  logic [7:0]  wdv  [2];

  cache_mem_arbiter #(
    .ADDR_W(16), .DATA_W(8), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .addr_c0(addr_c0), .rd_c0(rd_c0), .wr_c0(wr_c0), .wdata_c0(wdata_c0),
    .rdata_c0(rdata_c0), .ready_c0(ready_c0),
    .addr_c1(addr_c1), .rd_c1(rd_c1), .wr_c1(wr_c1), .wdata_c1(wdata_c1),
    .rdata_c1(rdata_c1), .ready_c1(ready_c1),
    .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem), .wdata_mem(wdata_mem),
    .rdata_mem(rdata_mem), .ready_mem(ready_mem),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL sim_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr,
                         input logic [15:0] a, input logic [7:0] d);
    if (c == 0) begin
      rd_c0 = rd; wr_c0 = wr; addr_c0 = a; wdata_c0 = d;
    end else begin
      rd_c1 = rd; wr_c1 = wr; addr_c1 = a; wdata_c1 = d;
    end
  endtask

  function automatic logic rdy(input int c);
    return (c == 0) ? ready_c0 : ready_c1;
  endfunction

  function automatic logic [7:0] rdat(input int c);
    return (c == 0) ? rdata_c0 : rdata_c1;
  endfunction

  function automatic logic [1:0] onehot(input int c);
    return (c == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    ready_mem = 1'b1;
    #1;
    @(negedge clock);
    reset_n = 1'b1;
    m_last = 1;
  endtask

  // Called at a negedge with the owner's request already driven; expects the
  // grant at the next edge, serves all beats, checks the gap, then releases.
  task automatic serve(input int own, input bit is_wr, input logic [15:0] a,
                       input logic [7:0] wd, input logic [31:0] data4,
                       input bit drop, input int stall_max);
    int nb;
    nb = is_wr ? 1 : BL;
    @(posedge clock); #1;
    check("grant", grant, onehot(own));
    check("addr_mem", addr_mem, a);
    check("rd_mem", rd_mem, !is_wr);
    check("wr_mem", wr_mem, is_wr);
    if (is_wr) check("wdata_mem", wdata_mem, wd);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, stall_max)) begin
        @(negedge clock);
        ready_mem = 1'b1;
        rdata_mem = 8'($urandom);
        #1;
        check("ready_stall", rdy(own), 1'b1);
        @(posedge clock); #1;
        check("grant_hold", grant, onehot(own));
      end
      @(negedge clock);
      ready_mem = 1'b0;
      rdata_mem = data4[8*b +: 8];
      if (drop && b == 2) set_req(own, 1'b0, 1'b0, a, wd);
      #1;
      check("ready_own", rdy(own), 1'b0);
      check("ready_other", rdy(1 - own), 1'b1);
      check("rdata", rdat(own), data4[8*b +: 8]);
      @(posedge clock); #1;
      if (b < nb - 1) check("grant_mid", grant, onehot(own));
    end
    check("gap_grant", grant, 2'b00);
    check("gap_strobe", {rd_mem, wr_mem}, 2'b00);
    @(negedge clock);
    ready_mem = 1'($urandom_range(0, 1));
    set_req(own, 1'b0, 1'b0, a, wd);
    #1;
    check("gap_ready", {ready_c1, ready_c0}, 2'b11);
    m_last = own;
  endtask

  initial begin
    int own;
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    ready_mem = 1'b1;
    rdata_mem = 8'h00;

    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_rd_mem", rd_mem, 1'b0);
    check("rst_wr_mem", wr_mem, 1'b0);
    check("rst_addr_mem", addr_mem, 16'h0);
    check("rst_wdata_mem", wdata_mem, 8'h0);
    check("rst_ready", {ready_c1, ready_c0}, 2'b11);
    check("rst_timeout_err", timeout_err, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single line-fill read by c0.
    @(negedge clock);
    set_req(0, 1'b1, 1'b0, 16'hC08B, 8'h00);
    serve(0, 1'b0, 16'hC08B, 8'h00, 32'h44332211, 1'b0, 0);

    // Write-through by c1.
    set_req(1, 1'b0, 1'b1, 16'h0093, 8'h23);
    serve(1, 1'b1, 16'h0093, 8'h23, 32'h0000005A, 1'b0, 0);

    // Contention from reset alternates c0, c1, c0, c1.
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h1000, 8'h00);
    set_req(1, 1'b1, 1'b0, 16'h2000, 8'h00);
    serve(0, 1'b0, 16'h1000, 8'h00, 32'hA1A2A3A4, 1'b0, 1);
    set_req(0, 1'b1, 1'b0, 16'h1100, 8'h00);
    serve(1, 1'b0, 16'h2000, 8'h00, 32'hB1B2B3B4, 1'b0, 1);
    set_req(1, 1'b1, 1'b0, 16'h2100, 8'h00);
    serve(0, 1'b0, 16'h1100, 8'h00, 32'hC1C2C3C4, 1'b0, 1);
    serve(1, 1'b0, 16'h2100, 8'h00, 32'hD1D2D3D4, 1'b0, 1);

    // c0 drops its read after beat 2 while c1 waits; burst still completes.
    set_req(0, 1'b1, 1'b0, 16'h3000, 8'h00);
    set_req(1, 1'b1, 1'b1, 16'h4000, 8'h77);
    serve(0, 1'b0, 16'h3000, 8'h00, 32'h0F1E2D3C, 1'b1, 1);
    serve(1, 1'b1, 16'h4000, 8'h77, 32'h00000099, 1'b0, 1);

    // Asynchronous reset in the middle of a burst.
    set_req(0, 1'b1, 1'b0, 16'h5555, 8'h00);
    @(posedge clock); #1;
    check("rstmid_grant", grant, 2'b01);
    repeat (2) begin
      @(negedge clock);
      ready_mem = 1'b0;
      @(posedge clock);
    end
    @(negedge clock);
    ready_mem = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_grant0", grant, 2'b00);
    check("rstmid_rd_mem", rd_mem, 1'b0);
    check("rstmid_addr_mem", addr_mem, 16'h0);
    check("rstmid_ready_c0", ready_c0, 1'b1);
    set_req(0, 1'b0, 1'b0, 16'h0, 8'h0);
    ready_mem = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    m_last = 1;

`ifdef ARB_WATCHDOG_EN
    // Read that never gets a beat: aborted after TO BUSY cycles.
    set_req(1, 1'b1, 1'b0, 16'h6000, 8'h00);
    @(posedge clock); #1;
    check("wd_grant", grant, 2'b10);
    repeat (TO - 1) @(posedge clock);
    #1;
    check("wd_still_busy", grant, 2'b10);
    check("wd_no_err_yet", timeout_err, 1'b0);
    @(posedge clock); #1;
    check("wd_abort_grant", grant, 2'b00);
    check("wd_err", timeout_err, 1'b1);
    @(negedge clock);
    set_req(1, 1'b0, 1'b0, 16'h0, 8'h0);
    m_last = 1;
    set_req(0, 1'b0, 1'b1, 16'h6100, 8'h5A);
    serve(0, 1'b1, 16'h6100, 8'h5A, 32'h00000011, 1'b0, 0);
    check("wd_err_sticky", timeout_err, 1'b1);
`else
    check("timeout_err_tied", timeout_err, 1'b0);
`endif

    // Randomized traffic against a transaction-level round-robin model.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int r = 0; r < 40; ) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && $urandom_range(0, 2) != 0) begin
          pend[c] = 1'b1;
          opw[c]  = 1'($urandom_range(0, 1));
          ad[c]   = 16'($urandom);
          wdv[c]  = 8'($urandom);
          set_req(c, opw[c] ? 1'($urandom_range(0, 1)) : 1'b1, opw[c], ad[c], wdv[c]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        ready_mem = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        check("idle_grant", grant, 2'b00);
        @(negedge clock);
        continue;
      end
      if (pend[0] && pend[1]) own = (m_last == 1) ? 0 : 1;
      else                    own = pend[0] ? 0 : 1;
      serve(own, opw[own], ad[own], wdv[own], $urandom,
            !opw[own] && ($urandom_range(0, 1) == 1), 2);
      pend[own] = 1'b0;
      r++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
